// File: rtl/kmap_lut_engine_if.sv
// kmap_lut_engine_if: programming, evaluation and scan signals of the LUT engine
interface kmap_lut_engine_if #(parameter int N = 4);
    localparam int CW = N + 1;
    logic prog_valid;
    logic prog_data;
    logic prog_ready;
    logic eval_valid;
    logic [N-1:0] x;
    logic out_valid;
    logic sop;
    logic pos;
    logic scan_start;
    logic scan_busy;
    logic scan_done;
    logic [CW-1:0] ones_count;
    logic table_valid;
    modport master (
        output prog_valid, prog_data, eval_valid, x, scan_start,
        input  prog_ready, out_valid, sop, pos, scan_busy, scan_done, ones_count, table_valid
    );
    modport slave (
        input  prog_valid, prog_data, eval_valid, x, scan_start,
        output prog_ready, out_valid, sop, pos, scan_busy, scan_done, ones_count, table_valid
    );
endinterface

// File: rtl/kmap_lut_engine.sv
// kmap_lut_engine: serially loaded N-input truth table with registered SOP/POS evaluation and minterm scan
module kmap_lut_engine #(parameter int N = 4) (
    input  logic clk,
    input  logic rst_n,
    kmap_lut_engine_if.slave bus
);
    localparam int D = 1 << N;
    localparam int CW = N + 1;
    typedef enum logic [1:0] {IDLE, PROG, SCAN} state_t;
    state_t state, state_n;
    logic [D-1:0] tbl;
    logic [N-1:0] idx;
    logic last, prog_we, scan_go, eval_go, sop_c, pos_c;
    assign last = &idx;
    assign bus.prog_ready = state != SCAN;
    always_comb begin
        prog_we = state != SCAN && bus.prog_valid;
        scan_go = state == IDLE && !bus.prog_valid && bus.scan_start && bus.table_valid;
        eval_go = state == IDLE && !bus.prog_valid && !bus.scan_start && bus.eval_valid && bus.table_valid;
        state_n = prog_we ? ((state == PROG && last) ? IDLE : PROG)
                : scan_go ? SCAN
                : (state == SCAN && last) ? IDLE : state;
    end
    // POS is the product of maxterms, kept apart from the SOP table lookup
    always_comb begin
        sop_c = tbl[bus.x];
        pos_c = 1'b1;
        for (int k = 0; k < D; k++)
            pos_c = pos_c & (tbl[k] | (bus.x != N'(k)));
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl <= '0;
            idx <= '0;
            bus.table_valid <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.sop <= 1'b0;
            bus.pos <= 1'b0;
            bus.scan_busy <= 1'b0;
            bus.scan_done <= 1'b0;
            bus.ones_count <= '0;
        end else begin
            bus.out_valid <= eval_go;
            bus.scan_done <= state == SCAN && last;
            if (eval_go) begin
                bus.sop <= sop_c;
                bus.pos <= pos_c;
            end
            if (prog_we) begin
                tbl[idx] <= bus.prog_data;
                idx <= idx + N'(1);
            end
            if (prog_we && state == IDLE) bus.table_valid <= 1'b0;
            if (prog_we && state == PROG && last) bus.table_valid <= 1'b1;
            if (scan_go) begin
                bus.ones_count <= '0;
                bus.scan_busy <= 1'b1;
            end
            if (state == SCAN) begin
                bus.ones_count <= bus.ones_count + CW'(tbl[idx]);
                idx <= idx + N'(1);
                if (last) bus.scan_busy <= 1'b0;
            end
        end
    end
endmodule
